// File: rtl/instr_encoder_loader_if.sv
// Request and imem-write bundle for instr_encoder_loader: field inputs with
// valid/ready handshake, imem write port, and status outputs.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 6
);
    logic              valid;
    logic              ready;
    logic [2:0]        itype;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [12:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [5:0]        ctrl_exp;

    modport master (
        output valid, itype, rd, rs1, rs2, funct3, funct7, imm,
        input  ready, imem_we, imem_addr, imem_data, count, full, err, ctrl_exp
    );

    modport slave (
        input  valid, itype, rd, rs1, rs2, funct3, funct7, imm,
        output ready, imem_we, imem_addr, imem_data, count, full, err, ctrl_exp
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes RISC-V I/R/S/L/B/jalr words from fields and writes them sequentially into imem.
// Define ENC_CTRL_CHECK_EN to register the expected decoder control pattern on ctrl_exp.
module instr_encoder_loader #(
    parameter int ADDR_W     = 6,
    parameter int START_ADDR = 0
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   clear,
    instr_encoder_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENC, WR, ERR} state_t;

    localparam logic [ADDR_W:0]   CAP   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

    state_t state, state_next;

    logic [2:0]        req_type;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [2:0]        req_f3;
    logic [6:0]        req_f7;
    logic [12:0]       req_imm;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [31:0]       data;
    logic              full;
    logic              accept;

    logic [31:0]       enc_word;
    logic              enc_bad;
    logic [5:0]        enc_ctrl;

    assign full   = (count == CAP);
    assign accept = (state == IDLE) && bus.valid && !full && !clear;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ENC;
            ENC: begin
                if (clear)        state_next = IDLE;
                else if (enc_bad) state_next = ERR;
                else              state_next = WR;
            end
            WR:      state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        enc_ctrl = '0;
        case (req_type)
            3'd0: begin
                enc_word = {req_imm[11:0], req_rs1, req_f3, req_rd, 7'b0010011};
                enc_ctrl = 6'b110000;
            end
            3'd1: begin
                enc_word = {req_f7, req_rs2, req_rs1, req_f3, req_rd, 7'b0110011};
                enc_ctrl = 6'b100000;
            end
            3'd2: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, req_f3, req_imm[4:0], 7'b0100011};
                enc_ctrl = 6'b010010;
            end
            3'd3: begin
                enc_word = {req_imm[11:0], req_rs1, req_f3, req_rd, 7'b0000011};
                enc_ctrl = 6'b110101;
            end
            3'd4: begin
                // Branch offsets are halfword-aligned; a set bit 0 cannot be encoded.
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_f3,
                            req_imm[4:1], req_imm[11], 7'b1100011};
                enc_ctrl = 6'b001000;
                enc_bad  = req_imm[0];
            end
            3'd5: begin
                enc_word = {req_imm[11:0], req_rs1, req_f3, req_rd, 7'b1100111};
                enc_ctrl = 6'b001000;
            end
            default: enc_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_type <= '0;
            req_rd   <= '0;
            req_rs1  <= '0;
            req_rs2  <= '0;
            req_f3   <= '0;
            req_f7   <= '0;
            req_imm  <= '0;
            addr     <= START;
            count    <= '0;
            data     <= '0;
        end else begin
            if (accept) begin
                req_type <= bus.itype;
                req_rd   <= bus.rd;
                req_rs1  <= bus.rs1;
                req_rs2  <= bus.rs2;
                req_f3   <= bus.funct3;
                req_f7   <= bus.funct7;
                req_imm  <= bus.imm;
            end
            // Clear wins over an in-flight encode or write.
            if (clear) begin
                addr  <= START;
                count <= '0;
            end else begin
                if (state == ENC && !enc_bad) data <= enc_word;
                if (state == WR) begin
                    addr  <= addr + 1'b1;
                    count <= count + 1'b1;
                end
            end
        end
    end

`ifdef ENC_CTRL_CHECK_EN
    logic [5:0] ctrl;

    always_ff @(posedge clk) begin
        if (rst)                         ctrl <= '0;
        else if (state == ENC && !clear) ctrl <= enc_ctrl;
    end

    assign bus.ctrl_exp = ctrl;
`else
    assign bus.ctrl_exp = '0;
`endif

    assign bus.ready     = (state == IDLE) && !full;
    assign bus.imem_we   = (state == WR) && !clear;
    assign bus.err       = (state == ERR);
    assign bus.imem_addr = addr;
    assign bus.imem_data = data;
    assign bus.count     = count;
    assign bus.full      = full;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (4-word imem) with a transaction-level
// reference model compared every cycle, plus hand-computed literal expectations.
module tb_instr_encoder_loader;
    localparam int AW    = 2;
    localparam int START = 0;
    localparam int CAP   = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clear = 1'b0;

    instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

    instr_encoder_loader #(.ADDR_W(AW), .START_ADDR(START)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [2:0] t, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [12:0] imm);
        logic [31:0] regs;
        logic [31:0] imm12;
        regs  = (32'(rs1) << 15) | (32'(f3) << 12);
        imm12 = 32'(imm[11:0]);
        case (t)
            3'd0: return (imm12 << 20) | regs | (32'(rd) << 7) | 32'h13;
            3'd1: return (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'h33;
            3'd2: return ((imm12 >> 5) << 25) | (32'(rs2) << 20) | regs
                         | ((imm12 & 32'h1F) << 7) | 32'h23;
            3'd3: return (imm12 << 20) | regs | (32'(rd) << 7) | 32'h03;
            3'd4: return (32'(imm[12]) << 31) | (32'(imm[10:5]) << 25) | (32'(rs2) << 20) | regs
                         | (32'(imm[4:1]) << 8) | (32'(imm[11]) << 7) | 32'h63;
            3'd5: return (imm12 << 20) | regs | (32'(rd) << 7) | 32'h67;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [5:0] ref_ctrl(input logic [2:0] t);
        case (t)
            3'd0: return 6'b110000;
            3'd1: return 6'b100000;
            3'd2: return 6'b010010;
            3'd3: return 6'b110101;
            3'd4: return 6'b001000;
            3'd5: return 6'b001000;
            default: return 6'b000000;
        endcase
    endfunction

    // Model: a request in flight has an age (1 = encoding, 2 = write/reject cycle).
    bit          m_live    = 0;
    bit          m_pending = 0;
    int          m_age     = 0;
    bit          m_bad     = 0;
    logic [31:0] m_word    = '0;
    logic [5:0]  m_cword   = '0;
    int          m_addr    = START;
    int          m_count   = 0;
    logic [31:0] m_data    = '0;
    logic [5:0]  m_ctrl    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_live    = 1;
            m_pending = 0;
            m_addr    = START;
            m_count   = 0;
            m_data    = '0;
            m_ctrl    = '0;
        end else if (clear) begin
            m_pending = 0;
            m_addr    = START;
            m_count   = 0;
        end else if (m_pending) begin
            if (m_age == 1) begin
                if (!m_bad) m_data = m_word;
`ifdef ENC_CTRL_CHECK_EN
                m_ctrl = m_cword;
`endif
                m_age = 2;
            end else begin
                if (!m_bad) begin
                    m_addr  = (m_addr + 1) % CAP;
                    m_count = m_count + 1;
                end
                m_pending = 0;
            end
        end else if (bus.valid && m_count < CAP) begin
            m_pending = 1;
            m_age     = 1;
            m_word    = ref_word(bus.itype, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7, bus.imm);
            m_cword   = ref_ctrl(bus.itype);
            m_bad     = (bus.itype > 3'd5) || (bus.itype == 3'd4 && bus.imm[0]);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("ready", 32'(bus.ready), 32'(!m_pending && m_count < CAP));
            check("imem_we", 32'(bus.imem_we), 32'(m_pending && m_age == 2 && !m_bad && !clear));
            check("err", 32'(bus.err), 32'(m_pending && m_age == 2 && m_bad));
            check("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
            check("imem_data", bus.imem_data, m_data);
            check("count", 32'(bus.count), 32'(m_count));
            check("full", 32'(bus.full), 32'(m_count == CAP));
            check("ctrl_exp", 32'(bus.ctrl_exp), 32'(m_ctrl));
        end
    end

    task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] imm);
        @(posedge clk); #1;
        bus.itype  = t;
        bus.rd     = rd;
        bus.rs1    = rs1;
        bus.rs2    = rs2;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.imm    = imm;
        bus.valid  = 1'b1;
        @(posedge clk); #1;
        bus.valid  = 1'b0;
    endtask

    // Called right after send(): the second following negedge is the write cycle.
    task automatic expect_write(input string name, input logic [31:0] word, input int a);
        @(negedge clk);
        @(negedge clk);
        check({name, "_we"}, 32'(bus.imem_we), 32'd1);
        check({name, "_data"}, bus.imem_data, word);
        check({name, "_addr"}, 32'(bus.imem_addr), 32'(a));
    endtask

    initial begin
        bus.valid  = 1'b0;
        bus.itype  = '0;
        bus.rd     = '0;
        bus.rs1    = '0;
        bus.rs2    = '0;
        bus.funct3 = '0;
        bus.funct7 = '0;
        bus.imm    = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_data", bus.imem_data, 32'h0);
        check("rst_we", 32'(bus.imem_we), 32'd0);

        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5);
        expect_write("I", 32'h00500093, 0);
        @(negedge clk);
        check("I_count", 32'(bus.count), 32'd1);

        send(3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
        expect_write("R", 32'h002081B3, 1);

        send(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 13'd8);
        expect_write("S", 32'h0020A423, 2);

        // Rejects: unsupported type, then misaligned branch offset.
        send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0);
        @(negedge clk);
        @(negedge clk);
        check("t7_err", 32'(bus.err), 32'd1);
        check("t7_we", 32'(bus.imem_we), 32'd0);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0003);
        @(negedge clk);
        @(negedge clk);
        check("bodd_err", 32'(bus.err), 32'd1);
        @(negedge clk);
        check("err_count", 32'(bus.count), 32'd3);

        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC);
        expect_write("B", 32'hFE208EE3, 3);
`ifdef ENC_CTRL_CHECK_EN
        check("B_ctrl", 32'(bus.ctrl_exp), 32'(6'b001000));
`endif
        @(negedge clk);
        check("full_count", 32'(bus.count), 32'd4);
        check("full_flag", 32'(bus.full), 32'd1);
        check("full_ready", 32'(bus.ready), 32'd0);
        check("wrap_addr", 32'(bus.imem_addr), 32'd0);

        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5);
        repeat (3) @(negedge clk);
        check("blocked_count", 32'(bus.count), 32'd4);

        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        check("clr_count", 32'(bus.count), 32'd0);
        check("clr_ready", 32'(bus.ready), 32'd1);

        // Clear coincident with valid in idle: not accepted.
        @(posedge clk); #1;
        bus.itype = 3'd0;
        bus.valid = 1'b1;
        clear     = 1'b1;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        clear     = 1'b0;
        repeat (3) @(negedge clk);
        check("clrvalid_count", 32'(bus.count), 32'd0);

        // Clear during encode.
        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd7);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        repeat (3) @(negedge clk);
        check("clrenc_count", 32'(bus.count), 32'd0);
        check("clrenc_ready", 32'(bus.ready), 32'd1);

        // Reset during encode.
        send(3'd1, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstenc_count", 32'(bus.count), 32'd0);
        check("rstenc_data", bus.imem_data, 32'h0);

        send(3'd0, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 13'h1FFF);
        expect_write("Ineg", 32'hFFF08113, 0);
        send(3'd3, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd4);
        expect_write("L", 32'h00412283, 1);
        send(3'd5, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 13'd0);
        expect_write("J", 32'h000280E7, 2);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
